// File: rtl/axi_pkg.sv
// Shared AXI constants and the FSM state types used by the default slave.
package axi_pkg;

  localparam int AXI_ID_BITS   = 4;
  localparam int AXI_IDS_BITS  = 8;
  localparam int AXI_ADDR_BITS = 32;
  localparam int AXI_DATA_BITS = 32;
  localparam int AXI_LEN_BITS  = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Master codes carried one-hot in ID[7:4].
  localparam logic [AXI_ID_BITS-1:0] M0 = 4'b0001;
  localparam logic [AXI_ID_BITS-1:0] M1 = 4'b0010;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

endpackage

// File: rtl/default_slave_rd.sv
// Read engine of the default slave: answers every AR burst with ARLen+1
// DECERR beats carrying DATA_PATTERN.
module default_slave_rd
  import axi_pkg::*;
#(
  parameter logic [AXI_DATA_BITS-1:0] DATA_PATTERN = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AXI_IDS_BITS-1:0]  ar_id,
  input  logic [AXI_LEN_BITS-1:0]  ar_len,
  input  logic                     ar_valid,
  output logic                     ar_ready,
  output logic [AXI_IDS_BITS-1:0]  r_id,
  output logic [AXI_DATA_BITS-1:0] r_data,
  output logic [1:0]               r_resp,
  output logic                     r_last,
  output logic                     r_valid,
  input  logic                     r_ready
);

  r_state_t                state_q, state_d;
  logic [AXI_IDS_BITS-1:0] id_q;
  logic [AXI_LEN_BITS-1:0] len_q;
  logic [AXI_LEN_BITS-1:0] beat_q;

  // NOTE: sequential state uses non-blocking assignments and an asynchronous
  // active-low reset; blocking here would race against readers of the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= R_IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      R_IDLE:  if (ar_valid)                     state_d = R_DATA;
      R_DATA:  if (r_valid && r_ready && r_last) state_d = R_IDLE;
      default:                                   state_d = R_IDLE;
    endcase
  end

  always_comb begin
    ar_ready = (state_q == R_IDLE);
    r_valid  = (state_q == R_DATA);
    r_id     = r_valid ? id_q : '0;
    r_resp   = r_valid ? RESP_DECERR : RESP_OKAY;
    r_last   = r_valid && (beat_q == len_q);
    r_data   = DATA_PATTERN;
  end

  // Beat counter never wraps: the last beat (beat == len) leaves R_DATA instead.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_q   <= '0;
      len_q  <= '0;
      beat_q <= '0;
    end else if (ar_valid && ar_ready) begin
      id_q   <= ar_id;
      len_q  <= ar_len;
      beat_q <= '0;
    end else if (r_valid && r_ready && !r_last) begin
      beat_q <= beat_q + 1'b1;
    end
  end

endmodule

// File: rtl/default_slave.sv
// AXI default slave: returns DECERR for every read and write burst.
// Optional DS_ERR_LOG_EN adds a saturating error counter and last-address capture.
module default_slave
  import axi_pkg::*;
#(
  parameter logic [AXI_DATA_BITS-1:0] DATA_PATTERN = 32'h0000_0000,
  parameter int                       ERR_CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [AXI_IDS_BITS-1:0]   DS_AWID,
  input  logic [AXI_ADDR_BITS-1:0]  DS_AWAddr,
  input  logic [AXI_LEN_BITS-1:0]   DS_AWLen,
  input  logic [2:0]                DS_AWSize,
  input  logic [1:0]                DS_AWBurst,
  input  logic                      DS_AWValid,
  output logic                      DS_AWReady,
  input  logic [AXI_DATA_BITS-1:0]  DS_WData,
  input  logic [3:0]                DS_WStrb,
  input  logic                      DS_WLast,
  input  logic                      DS_WValid,
  output logic                      DS_WReady,
  output logic [AXI_IDS_BITS-1:0]   DS_BID,
  output logic [1:0]                DS_BResp,
  output logic                      DS_BValid,
  input  logic                      DS_BReady,
  input  logic [AXI_IDS_BITS-1:0]   DS_ARID,
  input  logic [AXI_ADDR_BITS-1:0]  DS_ARAddr,
  input  logic [AXI_LEN_BITS-1:0]   DS_ARLen,
  input  logic [2:0]                DS_ARSize,
  input  logic [1:0]                DS_ARBurst,
  input  logic                      DS_ARValid,
  output logic                      DS_ARReady,
  output logic [AXI_IDS_BITS-1:0]   DS_RID,
  output logic [AXI_DATA_BITS-1:0]  DS_RData,
  output logic [1:0]                DS_RResp,
  output logic                      DS_RLast,
  output logic                      DS_RValid,
  input  logic                      DS_RReady
`ifdef DS_ERR_LOG_EN
  ,
  output logic [ERR_CNT_W-1:0]      err_cnt,
  output logic [AXI_ADDR_BITS-1:0]  err_addr
`endif
);

  default_slave_rd #(
    .DATA_PATTERN (DATA_PATTERN)
  ) u_rd (
    .clk      (clk),
    .rst      (rst),
    .ar_id    (DS_ARID),
    .ar_len   (DS_ARLen),
    .ar_valid (DS_ARValid),
    .ar_ready (DS_ARReady),
    .r_id     (DS_RID),
    .r_data   (DS_RData),
    .r_resp   (DS_RResp),
    .r_last   (DS_RLast),
    .r_valid  (DS_RValid),
    .r_ready  (DS_RReady)
  );

  w_state_t                w_state_q, w_state_d;
  logic [AXI_IDS_BITS-1:0] bid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) w_state_q <= W_IDLE;
    else      w_state_q <= w_state_d;
  end

  // WLast alone closes the burst; AWLen is deliberately ignored.
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (DS_AWValid)             w_state_d = W_DATA;
      W_DATA:  if (DS_WValid && DS_WLast)  w_state_d = W_RESP;
      W_RESP:  if (DS_BReady)              w_state_d = W_IDLE;
      default:                             w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    DS_AWReady = (w_state_q == W_IDLE);
    DS_WReady  = (w_state_q == W_DATA);
    DS_BValid  = (w_state_q == W_RESP);
    DS_BID     = DS_BValid ? bid_q : '0;
    DS_BResp   = DS_BValid ? RESP_DECERR : RESP_OKAY;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          bid_q <= '0;
    else if (DS_AWValid && DS_AWReady) bid_q <= DS_AWID;
  end

`ifdef DS_ERR_LOG_EN
  logic                 ar_hs, aw_hs;
  logic [1:0]           err_inc;
  logic [ERR_CNT_W:0]   err_sum;

  assign ar_hs   = DS_ARValid && DS_ARReady;
  assign aw_hs   = DS_AWValid && DS_AWReady;
  assign err_inc = {1'b0, ar_hs} + {1'b0, aw_hs};
  assign err_sum = {1'b0, err_cnt} + (ERR_CNT_W+1)'(err_inc);

  // Carry out of the widened sum means the counter would pass all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_cnt  <= '0;
      err_addr <= '0;
    end else begin
      err_cnt <= err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
      if (ar_hs)      err_addr <= DS_ARAddr;
      else if (aw_hs) err_addr <= DS_AWAddr;
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{DS_AWLen, DS_AWSize, DS_AWBurst, DS_WData, DS_WStrb,
                           DS_ARSize, DS_ARBurst};
`else
  localparam int unused_err_cnt_w = ERR_CNT_W;
  logic unused_inputs;
  assign unused_inputs = ^{DS_AWAddr, DS_AWLen, DS_AWSize, DS_AWBurst, DS_WData,
                           DS_WStrb, DS_ARAddr, DS_ARSize, DS_ARBurst};
`endif

endmodule

// File: tb/tb_default_slave.sv
// Randomized self-checking bench for default_slave; err_cnt/err_addr checks
// are compiled only when DS_ERR_LOG_EN is defined.
module tb_default_slave;

  localparam logic [31:0] PAT = 32'hDEAD_BEEF;
  localparam int          CW  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  DS_AWID = '0;
  logic [31:0] DS_AWAddr = '0;
  logic [3:0]  DS_AWLen = '0;
  logic [2:0]  DS_AWSize = '0;
  logic [1:0]  DS_AWBurst = '0;
  logic        DS_AWValid = 1'b0;
  logic        DS_AWReady;
  logic [31:0] DS_WData = '0;
  logic [3:0]  DS_WStrb = '0;
  logic        DS_WLast = 1'b0;
  logic        DS_WValid = 1'b0;
  logic        DS_WReady;
  logic [7:0]  DS_BID;
  logic [1:0]  DS_BResp;
  logic        DS_BValid;
  logic        DS_BReady = 1'b0;
  logic [7:0]  DS_ARID = '0;
  logic [31:0] DS_ARAddr = '0;
  logic [3:0]  DS_ARLen = '0;
  logic [2:0]  DS_ARSize = '0;
  logic [1:0]  DS_ARBurst = '0;
  logic        DS_ARValid = 1'b0;
  logic        DS_ARReady;
  logic [7:0]  DS_RID;
  logic [31:0] DS_RData;
  logic [1:0]  DS_RResp;
  logic        DS_RLast;
  logic        DS_RValid;
  logic        DS_RReady = 1'b0;
`ifdef DS_ERR_LOG_EN
  logic [CW-1:0] err_cnt;
  logic [31:0]   err_addr;
`endif

  int total = 0;
  int bad   = 0;
  int hs_count = 0;        // handshakes since reset, for the saturating-counter model
  logic [31:0] exp_addr = '0;

  default_slave #(.DATA_PATTERN(PAT), .ERR_CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .DS_AWID(DS_AWID), .DS_AWAddr(DS_AWAddr), .DS_AWLen(DS_AWLen), .DS_AWSize(DS_AWSize),
    .DS_AWBurst(DS_AWBurst), .DS_AWValid(DS_AWValid), .DS_AWReady(DS_AWReady),
    .DS_WData(DS_WData), .DS_WStrb(DS_WStrb), .DS_WLast(DS_WLast), .DS_WValid(DS_WValid),
    .DS_WReady(DS_WReady),
    .DS_BID(DS_BID), .DS_BResp(DS_BResp), .DS_BValid(DS_BValid), .DS_BReady(DS_BReady),
    .DS_ARID(DS_ARID), .DS_ARAddr(DS_ARAddr), .DS_ARLen(DS_ARLen), .DS_ARSize(DS_ARSize),
    .DS_ARBurst(DS_ARBurst), .DS_ARValid(DS_ARValid), .DS_ARReady(DS_ARReady),
    .DS_RID(DS_RID), .DS_RData(DS_RData), .DS_RResp(DS_RResp), .DS_RLast(DS_RLast),
    .DS_RValid(DS_RValid), .DS_RReady(DS_RReady)
`ifdef DS_ERR_LOG_EN
    , .err_cnt(err_cnt), .err_addr(err_addr)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat_cnt(input int n);
    int max_v = (1 << CW) - 1;
    return (n > max_v) ? max_v : n;
  endfunction

  task automatic check_err_log(input string tag);
`ifdef DS_ERR_LOG_EN
    total++;
    if (int'(err_cnt) !== sat_cnt(hs_count)) begin
      bad++;
      $display("FAIL %s err_cnt: got %0d want %0d", tag, err_cnt, sat_cnt(hs_count));
    end
    total++;
    if (err_addr !== exp_addr) begin
      bad++;
      $display("FAIL %s err_addr: got %h want %h", tag, err_addr, exp_addr);
    end
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // One full read burst; the model is "len+1 beats, last flagged on the final one".
  task automatic do_read(input logic [7:0] id, input logic [3:0] len,
                         input logic [31:0] addr, input int stall_pct);
    int k;
    int cyc;
    total++;
    if (DS_ARReady !== 1'b1) begin
      bad++; $display("FAIL rd_ar_ready_idle: got %b want 1", DS_ARReady);
    end
    DS_ARID = id; DS_ARLen = len; DS_ARAddr = addr;
    DS_ARSize = 3'($urandom); DS_ARBurst = 2'($urandom);
    DS_ARValid = 1'b1;
    step();
    DS_ARValid = 1'b0;
    hs_count++;
    exp_addr = addr;
    total++;
    if (DS_RValid !== 1'b1) begin
      bad++; $display("FAIL rd_first_beat_latency: rvalid got %b want 1", DS_RValid);
    end
    k = 0;
    cyc = 0;
    while (k <= int'(len) && cyc < 100) begin
      DS_RReady = ($urandom_range(99) >= stall_pct);
      total++;
      if ({DS_RValid, DS_RID, DS_RResp, DS_RLast, DS_RData, DS_ARReady}
          !== {1'b1, id, 2'b11, (k == int'(len)), PAT, 1'b0}) begin
        bad++;
        $display("FAIL rd_beat%0d: got v=%b id=%h resp=%b last=%b data=%h arrdy=%b want v=1 id=%h resp=11 last=%b data=%h arrdy=0",
                 k, DS_RValid, DS_RID, DS_RResp, DS_RLast, DS_RData, DS_ARReady,
                 id, (k == int'(len)), PAT);
      end
      step();
      if (DS_RReady) k++;
      cyc++;
    end
    DS_RReady = 1'b0;
    if (k <= int'(len)) begin
      total++; bad++;
      $display("FAIL rd_timeout: beats got %0d want %0d", k, int'(len) + 1);
    end
    total++;
    if ({DS_RValid, DS_RLast, DS_RID, DS_RResp, DS_ARReady} !== {1'b0, 1'b0, 8'h00, 2'b00, 1'b1}) begin
      bad++;
      $display("FAIL rd_after_last: got v=%b last=%b id=%h resp=%b arrdy=%b want 0 0 00 00 1",
               DS_RValid, DS_RLast, DS_RID, DS_RResp, DS_ARReady);
    end
  endtask

  // One full write burst of nbeats W beats, optionally with W presented before AW.
  task automatic do_write(input logic [7:0] id, input int nbeats, input logic [31:0] addr,
                          input bit pre_w, input int bdelay, input int stall_pct);
    int i;
    int cyc;
    if (pre_w) begin
      DS_WValid = 1'b1; DS_WLast = (nbeats == 1);
      step();
      total++;
      if ({DS_WReady, DS_AWReady} !== 2'b01) begin
        bad++; $display("FAIL wr_early_w_stall: got wrdy=%b awrdy=%b want 0 1", DS_WReady, DS_AWReady);
      end
    end
    total++;
    if (DS_AWReady !== 1'b1) begin
      bad++; $display("FAIL wr_aw_ready_idle: got %b want 1", DS_AWReady);
    end
    DS_AWID = id; DS_AWAddr = addr; DS_AWLen = 4'($urandom);
    DS_AWSize = 3'($urandom); DS_AWBurst = 2'($urandom);
    DS_AWValid = 1'b1;
    step();
    DS_AWValid = 1'b0;
    hs_count++;
    exp_addr = addr;
    i = 0;
    cyc = 0;
    while (i < nbeats && cyc < 100) begin
      DS_WValid = ($urandom_range(99) >= stall_pct);
      DS_WLast  = (i == nbeats - 1);
      DS_WData  = $urandom;
      DS_WStrb  = 4'($urandom);
      total++;
      if ({DS_WReady, DS_AWReady, DS_BValid} !== 3'b100) begin
        bad++;
        $display("FAIL wr_data_phase beat%0d: got wrdy=%b awrdy=%b bvalid=%b want 1 0 0",
                 i, DS_WReady, DS_AWReady, DS_BValid);
      end
      step();
      if (DS_WValid) i++;
      cyc++;
    end
    DS_WValid = 1'b0; DS_WLast = 1'b0;
    if (i < nbeats) begin
      total++; bad++;
      $display("FAIL wr_timeout: beats got %0d want %0d", i, nbeats);
    end
    for (int d = 0; d <= bdelay; d++) begin
      total++;
      if ({DS_BValid, DS_BID, DS_BResp, DS_WReady, DS_AWReady} !== {1'b1, id, 2'b11, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL wr_bresp wait%0d: got v=%b id=%h resp=%b wrdy=%b awrdy=%b want 1 %h 11 0 0",
                 d, DS_BValid, DS_BID, DS_BResp, DS_WReady, DS_AWReady, id);
      end
      DS_BReady = (d == bdelay);
      step();
    end
    DS_BReady = 1'b0;
    total++;
    if ({DS_BValid, DS_BID, DS_BResp, DS_AWReady} !== {1'b0, 8'h00, 2'b00, 1'b1}) begin
      bad++;
      $display("FAIL wr_after_b: got v=%b id=%h resp=%b awrdy=%b want 0 00 00 1",
               DS_BValid, DS_BID, DS_BResp, DS_AWReady);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    total++;
    if ({DS_RValid, DS_RLast, DS_RID, DS_RResp, DS_BValid, DS_BID, DS_BResp}
        !== {1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 2'b00}) begin
      bad++;
      $display("FAIL reset_outputs: got rv=%b rl=%b rid=%h rr=%b bv=%b bid=%h br=%b want all 0",
               DS_RValid, DS_RLast, DS_RID, DS_RResp, DS_BValid, DS_BID, DS_BResp);
    end
    step(); step();
    rst = 1'b1;
    hs_count = 0; exp_addr = '0;
    step();
    total++;
    if ({DS_ARReady, DS_AWReady, DS_WReady} !== 3'b110) begin
      bad++;
      $display("FAIL reset_ready: got ar=%b aw=%b w=%b want 1 1 0", DS_ARReady, DS_AWReady, DS_WReady);
    end
    check_err_log("reset");
  endtask

  task automatic test_read_directed();
    do_read(8'h13, 4'd3, 32'h1000_0040, 0);
    check_err_log("read_len3");
  endtask

  task automatic test_read_stall();
    DS_ARID = 8'h21; DS_ARLen = 4'd0; DS_ARAddr = 32'h2000_0000; DS_ARValid = 1'b1;
    step();
    DS_ARValid = 1'b0; hs_count++; exp_addr = 32'h2000_0000;
    DS_RReady = 1'b0;
    for (int c = 0; c < 4; c++) begin
      total++;
      if ({DS_RValid, DS_RLast, DS_RID, DS_RResp, DS_RData} !== {1'b1, 1'b1, 8'h21, 2'b11, PAT}) begin
        bad++;
        $display("FAIL rd_stall cycle%0d: got v=%b last=%b id=%h resp=%b data=%h want 1 1 21 11 %h",
                 c, DS_RValid, DS_RLast, DS_RID, DS_RResp, DS_RData, PAT);
      end
      DS_RReady = (c == 3);
      step();
    end
    DS_RReady = 1'b0;
    total++;
    if ({DS_RValid, DS_ARReady} !== 2'b01) begin
      bad++; $display("FAIL rd_stall_done: got v=%b arrdy=%b want 0 1", DS_RValid, DS_ARReady);
    end
  endtask

  task automatic test_write_directed();
    do_write(8'h25, 2, 32'h3000_0010, 1'b1, 3, 0);
    check_err_log("write_2beats");
  endtask

  task automatic test_simultaneous();
    fork
      do_read(8'h47, 4'd2, 32'hA000_0100, 30);
      do_write(8'h18, 3, 32'hB000_0200, 1'b0, 1, 30);
    join
    exp_addr = 32'hA000_0100;
    check_err_log("simultaneous");
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      do_read(8'($urandom), 4'($urandom_range(15)), $urandom, $urandom_range(50));
      check_err_log("rand_read");
      do_write(8'($urandom), $urandom_range(1, 5), $urandom, 1'($urandom), $urandom_range(3),
               $urandom_range(50));
      check_err_log("rand_write");
    end
    for (int n = 0; n < 3; n++) begin
      logic [31:0] ra;
      ra = $urandom;
      fork
        do_read(8'($urandom), 4'($urandom_range(15)), ra, $urandom_range(40));
        do_write(8'($urandom), $urandom_range(1, 4), $urandom, 1'b0, $urandom_range(3),
                 $urandom_range(40));
      join
      exp_addr = ra;
      check_err_log("rand_concurrent");
    end
  endtask

  task automatic test_reset_mid_burst();
    DS_ARID = 8'h5A; DS_ARLen = 4'd7; DS_ARAddr = 32'hC000_0000; DS_ARValid = 1'b1;
    step();
    DS_ARValid = 1'b0;
    DS_RReady = 1'b1;
    step();
    total++;
    if ({DS_RValid, DS_RLast} !== 2'b10) begin
      bad++; $display("FAIL rst_mid_beat2: got v=%b last=%b want 1 0", DS_RValid, DS_RLast);
    end
    DS_AWID = 8'h66; DS_AWValid = 1'b1;
    rst = 1'b0;
    #1;
    total++;
    if ({DS_RValid, DS_RID, DS_BValid} !== {1'b0, 8'h00, 1'b0}) begin
      bad++;
      $display("FAIL rst_mid_immediate: got rv=%b rid=%h bv=%b want 0 00 0", DS_RValid, DS_RID, DS_BValid);
    end
    DS_AWValid = 1'b0;
    step(); step();
    rst = 1'b1;
    hs_count = 0; exp_addr = '0;
    DS_WValid = 1'b1; DS_WLast = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      total++;
      if ({DS_RValid, DS_ARReady, DS_BValid, DS_WReady, DS_AWReady} !== 5'b01001) begin
        bad++;
        $display("FAIL rst_mid_after%0d: got rv=%b ar=%b bv=%b wr=%b aw=%b want 0 1 0 0 1",
                 c, DS_RValid, DS_ARReady, DS_BValid, DS_WReady, DS_AWReady);
      end
    end
    DS_WValid = 1'b0; DS_WLast = 1'b0; DS_RReady = 1'b0;
    check_err_log("rst_mid");
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 5; n++) begin
      fork
        do_read(8'h01, 4'd0, 32'hD000_0000 + 32'(n), 0);
        do_write(8'h02, 1, 32'hE000_0000 + 32'(n), 1'b0, 0, 0);
      join
      exp_addr = 32'hD000_0000 + 32'(n);
      check_err_log("saturation");
    end
  endtask

  initial begin
    test_reset();
    test_read_directed();
    test_read_stall();
    test_write_directed();
    test_simultaneous();
    test_random();
    test_reset_mid_burst();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/default_slave.md
DEFAULT_SLAVE -- requirements
Module: default_slave

Interface
REQ-001 SHALL have parameter DATA_PATTERN, default 32'h0000_0000, value driven on DS_RData for every beat.
REQ-002 SHALL have parameter ERR_CNT_W, default 16, width of the error counter (used only under DS_ERR_LOG_EN).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous, active-low.
REQ-005 SHALL have ports DS_AWID/DS_AWAddr/DS_AWLen/DS_AWSize/DS_AWBurst, input, 8/32/4/3/2, AW payload.
REQ-006 SHALL have ports DS_AWValid input 1 and DS_AWReady output 1, the AW handshake.
REQ-007 SHALL have ports DS_WData/DS_WStrb/DS_WLast/DS_WValid, input, 32/4/1/1, and DS_WReady, output, 1, the W channel.
REQ-008 SHALL have ports DS_BID/DS_BResp/DS_BValid, output, 8/2/1, and DS_BReady, input, 1, the B channel.
REQ-009 SHALL have ports DS_ARID/DS_ARAddr/DS_ARLen/DS_ARSize/DS_ARBurst, input, 8/32/4/3/2, AR payload.
REQ-010 SHALL have ports DS_ARValid input 1 and DS_ARReady output 1, the AR handshake.
REQ-011 SHALL have ports DS_RID/DS_RData/DS_RResp/DS_RLast/DS_RValid, output, 8/32/2/1/1, and DS_RReady, input, 1; these feed the read-data mux DS_R* inputs directly.
REQ-012 SHALL have ports err_cnt, output, ERR_CNT_W, and err_addr, output, 32, present only under DS_ERR_LOG_EN.

Function
REQ-013 SHALL run read and write engines independently; both may be busy in the same cycle.
REQ-014 Read FSM SHALL have states R_IDLE, R_DATA; DS_ARReady=1 only in R_IDLE.
REQ-015 On DS_ARValid&&DS_ARReady SHALL latch ARID (all 8 bits, master one-hot in [7:4]) and ARLen, clear the 4-bit beat counter, and enter R_DATA.
REQ-016 In R_DATA SHALL drive DS_RValid=1, DS_RID=latched ID, DS_RData=DATA_PATTERN, DS_RResp=2'b11 (DECERR), DS_RLast=(beat==latched len).
REQ-017 First DS_RValid SHALL assert exactly one cycle after the AR handshake; ARLen=N yields N+1 beats (max 16, no counter wrap).
REQ-018 On DS_RValid&&DS_RReady SHALL increment the beat counter, or return to R_IDLE if DS_RLast=1.
REQ-019 R outputs SHALL hold stable while DS_RValid=1 and DS_RReady=0; outside R_DATA, DS_RValid, DS_RLast, DS_RID and DS_RResp SHALL be 0.
REQ-020 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; DS_AWReady=1 only in W_IDLE and DS_WReady=1 only in W_DATA.
REQ-021 On the AW handshake SHALL latch AWID and enter W_DATA; W beats SHALL be accepted and discarded.
REQ-022 On DS_WValid&&DS_WReady&&DS_WLast SHALL enter W_RESP; AWLen is ignored and WLast alone terminates the burst.
REQ-023 In W_RESP SHALL drive DS_BValid=1, DS_BID=latched ID, DS_BResp=2'b11, held until DS_BReady, then return to W_IDLE.
REQ-024 W data arriving before its AW SHALL stall (DS_WReady=0 in W_IDLE).
REQ-025 Back-to-back bursts SHALL incur exactly one idle cycle (AR/AW ready re-asserts the cycle after the last R beat or B handshake).

Reset
REQ-026 On rst low SHALL force R_IDLE and W_IDLE, clear counters and latched IDs, and drive every valid, RLast, RID, BID and Resp output to 0, with DS_ARReady and DS_AWReady at 1 after release.
REQ-027 Reset mid-burst SHALL abandon the burst without emitting further beats or B responses.

Configuration
REQ-028 With macro DS_ERR_LOG_EN defined, err_cnt SHALL add 1 per AR handshake and 1 per AW handshake (2 if simultaneous), saturating at all-ones, and err_addr SHALL capture the handshaken address (ARAddr wins if simultaneous); both reset to 0.
REQ-029 Without DS_ERR_LOG_EN, err_cnt and err_addr and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-030 Shared package axi_pkg SHALL hold AXI_ID_BITS=4, AXI_IDS_BITS=8, AXI_ADDR_BITS=32, AXI_DATA_BITS=32, AXI_LEN_BITS=4, RESP_OKAY=2'b00, RESP_DECERR=2'b11 and master codes M0=4'b0001, M1=4'b0010.
REQ-031 The read engine SHALL be a sub-module default_slave_rd; the write FSM stays inline.

Verification
REQ-032 AR ID=8'h13, Len=3, RReady=1 -> 4 beats on consecutive cycles starting one cycle after the handshake, RID=8'h13, RResp=2'b11, RLast on beat 4 only.
REQ-033 AR Len=0 with RReady low for 3 cycles -> single beat held stable with RLast=1, completes on the 4th cycle.
REQ-034 AW ID=8'h25 then 2 W beats (WLast on 2nd) -> BValid the next cycle with BID=8'h25 and BResp=2'b11, held until BReady.
REQ-035 AR and AW in the same cycle -> both complete independently; under DS_ERR_LOG_EN err_cnt increments by 2 and err_addr equals ARAddr.
REQ-036 rst asserted during beat 2 of a Len=7 read -> RValid=0 immediately, no further beats, ARReady=1 after release.
